// File: rtl/vga_pkg.sv
// Shared VGA definitions: default timing, RGB888 colours and the pixel-source FSM states.
package vga_pkg;

    localparam int unsigned H_VALID_DEF = 640;
    localparam int unsigned V_VALID_DEF = 480;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BLACK  = 24'h000000;
    localparam rgb_t WHITE  = 24'hFFFFFF;
    localparam rgb_t RED    = 24'hFF0000;
    localparam rgb_t GREEN  = 24'h00FF00;
    localparam rgb_t BLUE   = 24'h0000FF;
    localparam rgb_t YELLOW = 24'hFFFF00;

    typedef enum logic {WAIT_SOF, RUN} state_e;

endpackage

// File: rtl/pic_window_src_if.sv
// Bundle between the display driver, the picture ROM and the pixel source stage.
interface pic_window_src_if
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
);
    logic [11:0]       H_Addr;
    logic [11:0]       V_Addr;
    logic              DataReq;
    logic [ADDR_W-1:0] Rom_Addr;
    logic              Rom_Rden;
    rgb_t              Rom_Q;
    rgb_t              Data;
    logic              Data_Valid;
    logic              Frame_Start;
    logic              Sync_Err;

    // Pixel source side.
    modport slave (
        input  H_Addr, V_Addr, DataReq, Rom_Q,
        output Rom_Addr, Rom_Rden, Data, Data_Valid, Frame_Start, Sync_Err
    );

    // Driver plus ROM side.
    modport master (
        output H_Addr, V_Addr, DataReq, Rom_Q,
        input  Rom_Addr, Rom_Rden, Data, Data_Valid, Frame_Start, Sync_Err
    );

endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous clear.
module pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift din through DEPTH stages; clear empties the whole line.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pic_window_src.sv
// Pixel source: picture ROM pixels inside a centred window, background colour elsewhere.
module pic_window_src
    import vga_pkg::*;
#(
    parameter int unsigned H_VALID  = H_VALID_DEF,
    parameter int unsigned V_VALID  = V_VALID_DEF,
    parameter int unsigned PIC_W    = 600,
    parameter int unsigned PIC_H    = 100,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned ROM_LAT  = 1,
    parameter rgb_t        BG_COLOR = WHITE
) (
    input  logic            Clk,
    input  logic            Rst,
    pic_window_src_if.slave bus
);

    localparam int unsigned     X0        = (H_VALID - PIC_W) / 2;
    localparam int unsigned     Y0        = (V_VALID - PIC_H) / 2;
    localparam longint unsigned PIC_SIZE  = longint'(PIC_W) * longint'(PIC_H);
    localparam logic [11:0]     X_LO      = 12'(X0);
    localparam logic [11:0]     X_HI      = 12'(X0 + PIC_W);
    localparam logic [11:0]     Y_LO      = 12'(Y0);
    localparam logic [11:0]     Y_HI      = 12'(Y0 + PIC_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

    if (PIC_W > H_VALID || PIC_H > V_VALID || PIC_SIZE > (64'd1 << ADDR_W) ||
        ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_params
        $fatal(1, "pic_window_src: illegal parameter set");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rden_q, rden_d;
    logic              err_q, err_d;
    logic              fs_q;
    rgb_t              data_q, data_d;
    logic              valid_q;
    logic              in_win, sof, rd_en, win_dly;

    assign in_win = bus.DataReq && (bus.H_Addr >= X_LO) && (bus.H_Addr < X_HI) &&
                    (bus.V_Addr >= Y_LO) && (bus.V_Addr < Y_HI);
    assign sof    = bus.DataReq && (bus.H_Addr == 12'd0) && (bus.V_Addr == 12'd0);
    // A sof in WAIT_SOF already belongs to the new frame, so it may read too.
    assign rd_en  = in_win && ((state_q == RUN) || sof);

    // Flag tracks the read through ROM_LAT cycles of ROM plus the address register.
    pipe_delay #(
        .WIDTH (1),
        .DEPTH (ROM_LAT + 1)
    ) u_win_dly (
        .clk  (Clk),
        .clr  (Rst),
        .din  (rd_en),
        .dout (win_dly)
    );

    // Next-state: FSM, frame-aligned address counter, sync check and output mux.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rden_d  = 1'b0;
        err_d   = err_q;
        data_d  = win_dly ? bus.Rom_Q : BG_COLOR;
        if (state_q == WAIT_SOF && sof) state_d = RUN;
        if (sof) begin
            // Previous frame must have consumed exactly PIC_SIZE pixels.
            if (state_q == RUN && cnt_q != '0) err_d = 1'b1;
            cnt_d = '0;
        end
        if (rd_en) begin
            rden_d = 1'b1;
            addr_d = sof ? '0 : cnt_q;
            if (sof) cnt_d = ADDR_W'(1);
            else     cnt_d = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= WAIT_SOF;
            cnt_q   <= '0;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            err_q   <= 1'b0;
            fs_q    <= 1'b0;
            data_q  <= BG_COLOR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            err_q   <= err_d;
            fs_q    <= sof;
            data_q  <= data_d;
            valid_q <= win_dly;
        end
    end

    assign bus.Rom_Addr    = addr_q;
    assign bus.Rom_Rden    = rden_q;
    assign bus.Data        = data_q;
    assign bus.Data_Valid  = valid_q;
    assign bus.Frame_Start = fs_q;
    assign bus.Sync_Err    = err_q;

endmodule

// File: tb/tb_pic_window_src.sv
// Scoreboard bench for pic_window_src: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus.
module tb_pic_window_src;
    import vga_pkg::*;

    localparam rgb_t        BG       = 24'hFFFFFF;
    localparam int unsigned PIC_SIZE = 60000;

    typedef struct {
        int unsigned cyc;
        logic [23:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] h = '0;
    logic [11:0] v = '0;
    logic        req = 1'b0;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_reads1 = 0;
    int          n_reads3 = 0;

    exp_t        rd1_q[$], rd3_q[$], dat1_q[$], dat3_q[$];
    int unsigned fs1_q[$], fs3_q[$];

    // Reference model state
    logic        m_run = 1'b0;
    int unsigned m_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pic_window_src_if #(.ADDR_W(16)) bus1 ();
    pic_window_src_if #(.ADDR_W(16)) bus3 ();

    assign bus1.H_Addr  = h;
    assign bus1.V_Addr  = v;
    assign bus1.DataReq = req;
    assign bus3.H_Addr  = h;
    assign bus3.V_Addr  = v;
    assign bus3.DataReq = req;

    function automatic rgb_t rom_word(input logic [15:0] a);
        return {8'h3C, a};
    endfunction

    // ROM models of latency 1 and 3
    rgb_t rom1_q;
    rgb_t rom3_p [3];
    always @(posedge clk) rom1_q <= rom_word(bus1.Rom_Addr);
    always @(posedge clk) begin
        rom3_p[0] <= rom_word(bus3.Rom_Addr);
        rom3_p[1] <= rom3_p[0];
        rom3_p[2] <= rom3_p[1];
    end
    assign bus1.Rom_Q = rom1_q;
    assign bus3.Rom_Q = rom3_p[2];

    pic_window_src #(.ROM_LAT(1)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));
    pic_window_src #(.ROM_LAT(3)) dut3 (.Clk(clk), .Rst(rst), .bus(bus3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read monitors
    always @(negedge clk) begin
        exp_t e;
        if (bus1.Rom_Rden) begin
            n_reads1++;
            if (rd1_q.size() == 0) chk("rd1_unexpected", 1, 0);
            else begin
                e = rd1_q.pop_front();
                chk("rd1_cycle", cyc, e.cyc);
                chk("rd1_addr", 32'(bus1.Rom_Addr), 32'(e.val));
            end
        end else if (rd1_q.size() != 0 && rd1_q[0].cyc <= cyc) begin
            e = rd1_q.pop_front();
            chk("rd1_missing", 0, 1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus3.Rom_Rden) begin
            n_reads3++;
            if (rd3_q.size() == 0) chk("rd3_unexpected", 1, 0);
            else begin
                e = rd3_q.pop_front();
                chk("rd3_cycle", cyc, e.cyc);
                chk("rd3_addr", 32'(bus3.Rom_Addr), 32'(e.val));
            end
        end else if (rd3_q.size() != 0 && rd3_q[0].cyc <= cyc) begin
            e = rd3_q.pop_front();
            chk("rd3_missing", 0, 1);
        end
    end

    // Pixel data monitors
    always @(negedge clk) begin
        exp_t e;
        if (bus1.Data_Valid) begin
            if (dat1_q.size() == 0) chk("dat1_unexpected", 1, 0);
            else begin
                e = dat1_q.pop_front();
                chk("dat1_cycle", cyc, e.cyc);
                chk("dat1_data", 32'(bus1.Data), 32'(e.val));
            end
        end else begin
            chk("dat1_bg", 32'(bus1.Data), 32'(BG));
            if (dat1_q.size() != 0 && dat1_q[0].cyc <= cyc) begin
                e = dat1_q.pop_front();
                chk("dat1_missing", 0, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus3.Data_Valid) begin
            if (dat3_q.size() == 0) chk("dat3_unexpected", 1, 0);
            else begin
                e = dat3_q.pop_front();
                chk("dat3_cycle", cyc, e.cyc);
                chk("dat3_data", 32'(bus3.Data), 32'(e.val));
            end
        end else begin
            chk("dat3_bg", 32'(bus3.Data), 32'(BG));
            if (dat3_q.size() != 0 && dat3_q[0].cyc <= cyc) begin
                e = dat3_q.pop_front();
                chk("dat3_missing", 0, 1);
            end
        end
    end

    // Frame_Start monitors
    always @(negedge clk) begin
        int unsigned c;
        if (bus1.Frame_Start) begin
            if (fs1_q.size() == 0) chk("fs1_unexpected", 1, 0);
            else begin
                c = fs1_q.pop_front();
                chk("fs1_cycle", cyc, c);
            end
        end else if (fs1_q.size() != 0 && fs1_q[0] <= cyc) begin
            c = fs1_q.pop_front();
            chk("fs1_missing", 0, 1);
        end
        if (bus3.Frame_Start) begin
            if (fs3_q.size() == 0) chk("fs3_unexpected", 1, 0);
            else begin
                c = fs3_q.pop_front();
                chk("fs3_cycle", cyc, c);
            end
        end else if (fs3_q.size() != 0 && fs3_q[0] <= cyc) begin
            c = fs3_q.pop_front();
            chk("fs3_missing", 0, 1);
        end
    end

    // One input cycle: drive at the falling edge, predict what the next rising edge causes.
    task automatic step(input logic r, input int hh, input int vv, input logic rq);
        int unsigned s;
        logic        sof, win, rd;
        exp_t        e;
        @(negedge clk);
        rst = r;
        h   = 12'(hh);
        v   = 12'(vv);
        req = rq;
        s   = cyc + 1;
        if (r) begin
            m_run = 1'b0;
            m_cnt = 0;
            // Anything due at or after the reset edge never appears.
            while (rd1_q.size() != 0 && rd1_q[rd1_q.size()-1].cyc >= s) void'(rd1_q.pop_back());
            while (rd3_q.size() != 0 && rd3_q[rd3_q.size()-1].cyc >= s) void'(rd3_q.pop_back());
            while (dat1_q.size() != 0 && dat1_q[dat1_q.size()-1].cyc >= s) void'(dat1_q.pop_back());
            while (dat3_q.size() != 0 && dat3_q[dat3_q.size()-1].cyc >= s) void'(dat3_q.pop_back());
            while (fs1_q.size() != 0 && fs1_q[fs1_q.size()-1] >= s) void'(fs1_q.pop_back());
            while (fs3_q.size() != 0 && fs3_q[fs3_q.size()-1] >= s) void'(fs3_q.pop_back());
        end else begin
            sof = rq && hh == 0 && vv == 0;
            win = rq && hh >= 20 && hh < 620 && vv >= 190 && vv < 290;
            rd  = win && (m_run || sof);
            if (rd) begin
                e.cyc = s;
                e.val = sof ? 24'd0 : 24'(m_cnt);
                rd1_q.push_back(e);
                rd3_q.push_back(e);
                e.val = rom_word(e.val[15:0]);
                e.cyc = s + 2;
                dat1_q.push_back(e);
                e.cyc = s + 4;
                dat3_q.push_back(e);
            end
            if (sof) begin
                m_run = 1'b1;
                m_cnt = rd ? 1 : 0;
                fs1_q.push_back(s);
                fs3_q.push_back(s);
            end else if (rd) begin
                m_cnt = (m_cnt == PIC_SIZE - 1) ? 0 : m_cnt + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1000, 1000, 1'b0);
    endtask

    task automatic check_reset();
        chk("rst_addr1", 32'(bus1.Rom_Addr), 0);
        chk("rst_rden1", 32'(bus1.Rom_Rden), 0);
        chk("rst_data1", 32'(bus1.Data), 32'(BG));
        chk("rst_valid1", 32'(bus1.Data_Valid), 0);
        chk("rst_fs1", 32'(bus1.Frame_Start), 0);
        chk("rst_err1", 32'(bus1.Sync_Err), 0);
        chk("rst_addr3", 32'(bus3.Rom_Addr), 0);
        chk("rst_rden3", 32'(bus3.Rom_Rden), 0);
        chk("rst_data3", 32'(bus3.Data), 32'(BG));
        chk("rst_valid3", 32'(bus3.Data_Valid), 0);
        chk("rst_fs3", 32'(bus3.Frame_Start), 0);
        chk("rst_err3", 32'(bus3.Sync_Err), 0);
    endtask

    task automatic check_err(input logic exp);
        chk("sync_err1", 32'(bus1.Sync_Err), 32'(exp));
        chk("sync_err3", 32'(bus3.Sync_Err), 32'(exp));
    endtask

    initial begin
        int base1, base3;

        // Reset, then a window sweep without sof: no reads, background only
        step(1'b1, 0, 0, 1'b0);
        step(1'b1, 0, 0, 1'b0);
        idle(1);
        check_reset();
        for (int r = 190; r < 192; r++)
            for (int c = 0; c < 640; c++) step(1'b0, c, r, 1'b1);
        idle(6);
        chk("nosof_reads1", 32'(n_reads1), 0);
        chk("nosof_reads3", 32'(n_reads3), 0);

        // sof, first window pixel, both horizontal edges, last window pixel
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 20, 190, 1'b1);
        step(1'b0, 19, 190, 1'b1);
        step(1'b0, 620, 190, 1'b1);
        step(1'b0, 619, 289, 1'b1);
        step(1'b0, 30, 200, 1'b0);
        idle(6);
        chk("dir_reads1", 32'(n_reads1), 2);
        chk("dir_hold_addr1", 32'(bus1.Rom_Addr), 1);
        chk("dir_hold_addr3", 32'(bus3.Rom_Addr), 1);
        check_err(1'b0);

        // Clean frame: every window pixel read exactly once
        step(1'b1, 0, 0, 1'b0);
        idle(1);
        base1 = n_reads1;
        base3 = n_reads3;
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 25, 189, 1'b1);
        for (int r = 190; r < 290; r++)
            for (int c = 0; c < 640; c++) step(1'b0, c, r, 1'b1);
        step(1'b0, 25, 290, 1'b1);
        idle(6);
        chk("frame_reads1", 32'(n_reads1 - base1), 60000);
        chk("frame_reads3", 32'(n_reads3 - base3), 60000);
        chk("frame_last_addr1", 32'(bus1.Rom_Addr), 59999);
        chk("frame_last_addr3", 32'(bus3.Rom_Addr), 59999);

        // Next frame is aligned; abort it after 1000 window pixels
        step(1'b0, 0, 0, 1'b1);
        idle(2);
        check_err(1'b0);
        for (int k = 0; k < 1000; k++) step(1'b0, 20 + k % 600, 190 + k / 600, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        idle(2);
        check_err(1'b1);
        step(1'b0, 20, 190, 1'b1);
        step(1'b0, 21, 190, 1'b1);
        idle(6);
        check_err(1'b1);

        // Reset in the middle of the window drops in-flight pixels
        for (int c = 22; c < 26; c++) step(1'b0, c, 190, 1'b1);
        step(1'b1, 26, 190, 1'b1);
        idle(1);
        check_reset();
        base1 = n_reads1;
        for (int c = 30; c < 40; c++) step(1'b0, c, 190, 1'b1);
        idle(6);
        chk("postrst_reads1", 32'(n_reads1 - base1), 0);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 20, 190, 1'b1);
        step(1'b0, 21, 190, 1'b1);
        idle(8);

        chk("left_rd1", rd1_q.size(), 0);
        chk("left_rd3", rd3_q.size(), 0);
        chk("left_dat1", dat1_q.size(), 0);
        chk("left_dat3", dat3_q.size(), 0);
        chk("left_fs1", fs1_q.size(), 0);
        chk("left_fs3", fs3_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
